// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter
//
// Shares one single-port synchronous VRAM between a camera capture path
// (writes) and a display scan-out path (reads). Display reads always win the
// slot. Capture writes wait in a small FIFO and drain through otherwise idle
// slots.
//
// Request semantics:
//   WR_REQ and RD_REQ are one-cycle strobes. There is no ready signal.
//   A read strobe is always accepted. It gets the RAM slot on the next edge.
//   An in-range write strobe is accepted when the FIFO has room after this
//   cycle's pop. If it is not accepted, it is dropped and OVERFLOW is set.
//   A write strobe whose address is outside the frame is ignored silently.
//   RD_VALID pulses once for each accepted read, two edges after the edge
//   that sampled RD_REQ.
//
// Ports:
//   CLK, RST_N            clock; asynchronous active-low reset
//   WR_REQ/WR_ADDR/WR_DATA  capture-side pixel write strobe
//   RD_REQ/RD_ADDR          display-side read strobe
//   RD_VALID/RD_DATA        read return (RD_DATA holds between pulses)
//   RAM_EN/RAM_WE/RAM_ADDR/RAM_WDATA  registered VRAM control
//   RAM_RDATA               VRAM read data, one cycle after a read enable
//   FIFO_LEVEL              write-buffer occupancy
//   OVERFLOW/CLR_OVF        sticky dropped-write flag and its clear
// -----------------------------------------------------------------------------
module vram_arbiter #(
    parameter int ADDR_W       = 15,
    parameter int DATA_W       = 8,
    parameter int FRAME_PIXELS = 23040,
    parameter int FIFO_DEPTH   = 4      // power of two, at least 2
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic                          WR_REQ,
    input  logic [ADDR_W-1:0]             WR_ADDR,
    input  logic [DATA_W-1:0]             WR_DATA,
    input  logic                          RD_REQ,
    input  logic [ADDR_W-1:0]             RD_ADDR,
    output logic                          RD_VALID,
    output logic [DATA_W-1:0]             RD_DATA,
    output logic                          RAM_EN,
    output logic                          RAM_WE,
    output logic [ADDR_W-1:0]             RAM_ADDR,
    output logic [DATA_W-1:0]             RAM_WDATA,
    input  logic [DATA_W-1:0]             RAM_RDATA,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
    output logic                          OVERFLOW,
    input  logic                          CLR_OVF
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0]  LVL_ONE   = LVL_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
    // One extra bit, so that a frame filling the whole address space still compares correctly.
    localparam logic [ADDR_W:0]   FRAME_LIM = (ADDR_W+1)'(FRAME_PIXELS);

    typedef enum logic [1:0] {
        SLOT_IDLE  = 2'd0,
        SLOT_READ  = 2'd1,
        SLOT_WRITE = 2'd2
    } slot_e;

    // Write buffer storage.
    logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [LVL_W-1:0]  r_level;
    logic              r_ovf;

    // RAM control and read-return pipeline.
    logic              r_ram_en;
    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_wdata;
    logic              r_rd_pend;   // RAM_RDATA carries a read result this cycle
    logic              r_rd_valid;
    logic [DATA_W-1:0] r_rd_data;

    slot_e             w_slot;
    logic              w_pop;
    logic              w_full;
    logic              w_in_range;
    logic              w_push;
    logic              w_drop;

    // Slot decision. A read strobe takes the slot. Otherwise a non-empty FIFO drains its head.
    always_comb begin
        w_slot = SLOT_IDLE;
        if (RD_REQ) begin
            w_slot = SLOT_READ;
        end else if (r_level != '0) begin
            w_slot = SLOT_WRITE;
        end
    end

    assign w_pop      = (w_slot == SLOT_WRITE);
    assign w_full     = (r_level == LVL_FULL);
    assign w_in_range = WR_REQ && ({1'b0, WR_ADDR} < FRAME_LIM);
    // When the FIFO is full, a pop in the same cycle frees the slot that this push takes.
    assign w_push     = w_in_range && (!w_full || w_pop);
    assign w_drop     = w_in_range && w_full && !w_pop;

    // FIFO storage is not reset. Only the pointers and the level define what the FIFO holds.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= WR_ADDR;
            r_fifo_data[r_wr_ptr] <= WR_DATA;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
            // If a new drop happens in the same cycle as a clear, the flag stays set.
            r_ovf <= w_drop | (r_ovf & ~CLR_OVF);
        end
    end

    // Registered RAM control. On an idle slot only the enables drop.
    // The address and write data keep their last values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
        end else begin
            case (w_slot)
                SLOT_READ: begin
                    r_ram_en   <= 1'b1;
                    r_ram_we   <= 1'b0;
                    r_ram_addr <= RD_ADDR;
                end
                SLOT_WRITE: begin
                    r_ram_en    <= 1'b1;
                    r_ram_we    <= 1'b1;
                    r_ram_addr  <= r_fifo_addr[r_rd_ptr];
                    r_ram_wdata <= r_fifo_data[r_rd_ptr];
                end
                default: begin
                    r_ram_en <= 1'b0;
                    r_ram_we <= 1'b0;
                end
            endcase
        end
    end

    // Read return. The read enable goes out on edge N+0. The RAM answers during the
    // cycle after edge N+1, and that data is captured on edge N+2.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rd_pend  <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_pend  <= r_ram_en && !r_ram_we;
            r_rd_valid <= r_rd_pend;
            if (r_rd_pend) begin
                r_rd_data <= RAM_RDATA;
            end
        end
    end

    assign RAM_EN     = r_ram_en;
    assign RAM_WE     = r_ram_we;
    assign RAM_ADDR   = r_ram_addr;
    assign RAM_WDATA  = r_ram_wdata;
    assign RD_VALID   = r_rd_valid;
    assign RD_DATA    = r_rd_data;
    assign FIFO_LEVEL = r_level;
    assign OVERFLOW   = r_ovf;

endmodule

// File: tb/tb_vram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vram_arbiter
//
// Directed bench for vram_arbiter.
//
// A table of per-cycle vectors drives the DUT. Each vector gives the inputs for
// one cycle and the outputs expected just after the following rising edge.
// Hand-written sequences cover two cases:
//   - an overflow that lands in the same cycle as a clear
//   - a reset asserted while writes are buffered and reads are in flight
//
// The VRAM model returns addr[7:0] ^ 8'h39 one cycle after a read enable,
// so address 5 reads back as 8'h3C.
// -----------------------------------------------------------------------------
module tb_vram_arbiter;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 8;

    // ---------------- clock / reset ----------------
    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    always #5 clk = ~clk;

    logic              wr_req = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              rd_req = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic              clr_ovf = 1'b0;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata = '0;
    logic [2:0]        fifo_level;
    logic              overflow;

    vram_arbiter dut (
        .CLK        (clk),
        .RST_N      (rst_n),
        .WR_REQ     (wr_req),
        .WR_ADDR    (wr_addr),
        .WR_DATA    (wr_data),
        .RD_REQ     (rd_req),
        .RD_ADDR    (rd_addr),
        .RD_VALID   (rd_valid),
        .RD_DATA    (rd_data),
        .RAM_EN     (ram_en),
        .RAM_WE     (ram_we),
        .RAM_ADDR   (ram_addr),
        .RAM_WDATA  (ram_wdata),
        .RAM_RDATA  (ram_rdata),
        .FIFO_LEVEL (fifo_level),
        .OVERFLOW   (overflow),
        .CLR_OVF    (clr_ovf)
    );

    // Synchronous single-port VRAM model (read side only; writes are checked on the bus).
    always @(posedge clk) begin
        if (ram_en && !ram_we) begin
            ram_rdata <= ram_addr[7:0] ^ 8'h39;
        end
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic wr, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                         input logic rd, input logic [ADDR_W-1:0] ra, input logic clr);
        wr_req  = wr;
        wr_addr = wa;
        wr_data = wd;
        rd_req  = rd;
        rd_addr = ra;
        clr_ovf = clr;
    endtask

    // Advance one edge, then sample away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic              wr;
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
        logic              rd;
        logic [ADDR_W-1:0] raddr;
        logic              clr;
        logic              en;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wd;
        logic [2:0]        lvl;
        logic              ovf;
        logic              rv;
        logic [DATA_W-1:0] rdat;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic wr, input logic [ADDR_W-1:0] waddr, input logic [DATA_W-1:0] wdata,
                           input logic rd, input logic [ADDR_W-1:0] raddr, input logic clr,
                           input logic en, input logic we, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wd, input logic [2:0] lvl, input logic ovf,
                           input logic rv, input logic [DATA_W-1:0] rdat);
        vec_t v;
        v.wr = wr; v.waddr = waddr; v.wdata = wdata;
        v.rd = rd; v.raddr = raddr; v.clr = clr;
        v.en = en; v.we = we; v.addr = addr; v.wd = wd;
        v.lvl = lvl; v.ovf = ovf; v.rv = rv; v.rdat = rdat;
        vecs.push_back(v);
    endtask

    task automatic check_all(input string tag, input vec_t v);
        check({tag, " ram_en"},    32'(ram_en),     32'(v.en));
        check({tag, " ram_we"},    32'(ram_we),     32'(v.we));
        check({tag, " ram_addr"},  32'(ram_addr),   32'(v.addr));
        check({tag, " ram_wdata"}, 32'(ram_wdata),  32'(v.wd));
        check({tag, " level"},     32'(fifo_level), 32'(v.lvl));
        check({tag, " overflow"},  32'(overflow),   32'(v.ovf));
        check({tag, " rd_valid"},  32'(rd_valid),   32'(v.rv));
        check({tag, " rd_data"},   32'(rd_data),    32'(v.rdat));
    endtask

    initial begin
        //        wr  waddr  wdata rd raddr clr | en we addr   wd    lvl ovf rv rdat
        // single buffered write
        add_vec(1, 100,   'hA5, 0, 0,  0,   0, 0, 0,     'h00, 1, 0, 0, 'h00);
        add_vec(0, 0,     'h00, 0, 0,  0,   1, 1, 100,   'hA5, 0, 0, 0, 'h00);
        add_vec(0, 0,     'h00, 0, 0,  0,   0, 0, 100,   'hA5, 0, 0, 0, 'h00);
        // single read, fixed latency
        add_vec(0, 0,     'h00, 1, 5,  0,   1, 0, 5,     'hA5, 0, 0, 0, 'h00);
        add_vec(0, 0,     'h00, 0, 0,  0,   0, 0, 5,     'hA5, 0, 0, 0, 'h00);
        add_vec(0, 0,     'h00, 0, 0,  0,   0, 0, 5,     'hA5, 0, 0, 1, 'h3C);
        add_vec(0, 0,     'h00, 0, 0,  0,   0, 0, 5,     'hA5, 0, 0, 0, 'h3C);
        // 6 reads vs 5 writes: reads first, 5th write dropped
        add_vec(1, 200,   'h10, 1, 10, 0,   1, 0, 10,    'hA5, 1, 0, 0, 'h3C);
        add_vec(1, 201,   'h11, 1, 11, 0,   1, 0, 11,    'hA5, 2, 0, 0, 'h3C);
        add_vec(1, 202,   'h12, 1, 12, 0,   1, 0, 12,    'hA5, 3, 0, 1, 'h33);
        add_vec(1, 203,   'h13, 1, 13, 0,   1, 0, 13,    'hA5, 4, 0, 1, 'h32);
        add_vec(1, 204,   'h14, 1, 14, 0,   1, 0, 14,    'hA5, 4, 1, 1, 'h35);
        add_vec(0, 0,     'h00, 1, 15, 0,   1, 0, 15,    'hA5, 4, 1, 1, 'h34);
        add_vec(0, 0,     'h00, 0, 0,  0,   1, 1, 200,   'h10, 3, 1, 1, 'h37);
        add_vec(0, 0,     'h00, 0, 0,  0,   1, 1, 201,   'h11, 2, 1, 1, 'h36);
        add_vec(0, 0,     'h00, 0, 0,  0,   1, 1, 202,   'h12, 1, 1, 0, 'h36);
        add_vec(0, 0,     'h00, 0, 0,  1,   1, 1, 203,   'h13, 0, 0, 0, 'h36);
        add_vec(0, 0,     'h00, 0, 0,  0,   0, 0, 203,   'h13, 0, 0, 0, 'h36);
        // out-of-frame writes are ignored
        add_vec(1, 23040, 'h77, 0, 0,  0,   0, 0, 203,   'h13, 0, 0, 0, 'h36);
        add_vec(1, 23200, 'h88, 0, 0,  0,   0, 0, 203,   'h13, 0, 0, 0, 'h36);
        add_vec(0, 0,     'h00, 0, 0,  0,   0, 0, 203,   'h13, 0, 0, 0, 'h36);
        // fill with the last in-frame address, then push+pop while full
        add_vec(1, 23039, 'hE0, 1, 0,  0,   1, 0, 0,     'h13, 1, 0, 0, 'h36);
        add_vec(1, 1000,  'hE1, 1, 1,  0,   1, 0, 1,     'h13, 2, 0, 0, 'h36);
        add_vec(1, 1001,  'hE2, 1, 2,  0,   1, 0, 2,     'h13, 3, 0, 1, 'h39);
        add_vec(1, 1002,  'hE3, 1, 3,  0,   1, 0, 3,     'h13, 4, 0, 1, 'h38);
        add_vec(1, 1003,  'hE4, 0, 0,  0,   1, 1, 23039, 'hE0, 4, 0, 1, 'h3B);
        add_vec(1, 1004,  'hE5, 0, 0,  0,   1, 1, 1000,  'hE1, 4, 0, 1, 'h3A);
        add_vec(0, 0,     'h00, 0, 0,  0,   1, 1, 1001,  'hE2, 3, 0, 0, 'h3A);
        add_vec(0, 0,     'h00, 0, 0,  0,   1, 1, 1002,  'hE3, 2, 0, 0, 'h3A);
        add_vec(0, 0,     'h00, 0, 0,  0,   1, 1, 1003,  'hE4, 1, 0, 0, 'h3A);
        add_vec(0, 0,     'h00, 0, 0,  0,   1, 1, 1004,  'hE5, 0, 0, 0, 'h3A);
        add_vec(0, 0,     'h00, 0, 0,  0,   0, 0, 1004,  'hE5, 0, 0, 0, 'h3A);

        // ---------------- reset ----------------
        #1 rst_n = 1'b0;
        #2;
        check("reset ram_en",    32'(ram_en),     32'd0);
        check("reset ram_we",    32'(ram_we),     32'd0);
        check("reset ram_addr",  32'(ram_addr),   32'd0);
        check("reset ram_wdata", 32'(ram_wdata),  32'd0);
        check("reset rd_valid",  32'(rd_valid),   32'd0);
        check("reset rd_data",   32'(rd_data),    32'd0);
        check("reset level",     32'(fifo_level), 32'd0);
        check("reset overflow",  32'(overflow),   32'd0);
        step();
        step();
        rst_n = 1'b1;

        // ---------------- table ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].wr, vecs[i].waddr, vecs[i].wdata, vecs[i].rd, vecs[i].raddr, vecs[i].clr);
            step();
            check_all($sformatf("vec%0d", i), vecs[i]);
        end

        // ---------------- overflow coinciding with clear ----------------
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ADDR_W'(300 + i), DATA_W'(i), 1'b1, ADDR_W'(20 + i), 1'b0);
            step();
            check($sformatf("fill%0d level", i), 32'(fifo_level), 32'(i + 1));
        end
        drive(1'b1, 304, 'h55, 1'b1, 24, 1'b1);
        step();
        check("ovf+clr overflow", 32'(overflow),   32'd1);
        check("ovf+clr level",    32'(fifo_level), 32'd4);
        drive(1'b0, 0, 0, 1'b1, 25, 1'b1);
        step();
        check("clr overflow", 32'(overflow),   32'd0);
        check("clr level",    32'(fifo_level), 32'd4);
        drive(1'b0, 0, 0, 1'b0, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("drain%0d ram_we", i),    32'(ram_en && ram_we), 32'd1);
            check($sformatf("drain%0d ram_addr", i),  32'(ram_addr),   32'(300 + i));
            check($sformatf("drain%0d ram_wdata", i), 32'(ram_wdata),  32'(i));
            check($sformatf("drain%0d level", i),     32'(fifo_level), 32'(3 - i));
        end
        step();
        step();
        step();

        // ---------------- reset mid-operation ----------------
        drive(1'b1, 400, 'hA0, 1'b1, 39, 1'b0);
        step();
        drive(1'b1, 401, 'hA1, 1'b1, 40, 1'b0);
        step();
        drive(1'b1, 402, 'hA2, 1'b1, 41, 1'b0);
        step();
        check("pre-reset level", 32'(fifo_level), 32'd3);
        drive(1'b0, 0, 0, 1'b0, 0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst ram_en",    32'(ram_en),     32'd0);
        check("midrst ram_we",    32'(ram_we),     32'd0);
        check("midrst ram_addr",  32'(ram_addr),   32'd0);
        check("midrst ram_wdata", 32'(ram_wdata),  32'd0);
        check("midrst rd_valid",  32'(rd_valid),   32'd0);
        check("midrst rd_data",   32'(rd_data),    32'd0);
        check("midrst level",     32'(fifo_level), 32'd0);
        check("midrst overflow",  32'(overflow),   32'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("post-reset%0d ram_en", i),   32'(ram_en),     32'd0);
            check($sformatf("post-reset%0d rd_valid", i), 32'(rd_valid),   32'd0);
            check($sformatf("post-reset%0d level", i),    32'(fifo_level), 32'd0);
        end

        // ---------------- report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, VRAM address width.
REQ-002 SHALL have parameter DATA_W, default 8, VRAM data width.
REQ-003 SHALL have parameter FRAME_PIXELS, default 23040, number of valid pixel addresses (160x144).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, write-buffer entries (power of two).
REQ-005 SHALL provide port CLK, input, 1, sole clock; all logic on rising edge.
REQ-006 SHALL provide port RST_N, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL provide port WR_REQ, input, 1, capture-side pixel write strobe, one write per asserted cycle.
REQ-008 SHALL provide port WR_ADDR, input, ADDR_W, capture write address.
REQ-009 SHALL provide port WR_DATA, input, DATA_W, capture write pixel.
REQ-010 SHALL provide port RD_REQ, input, 1, display-side read strobe, one read per asserted cycle.
REQ-011 SHALL provide port RD_ADDR, input, ADDR_W, display read address.
REQ-012 SHALL provide port RD_VALID, output, 1, read data valid pulse.
REQ-013 SHALL provide port RD_DATA, output, DATA_W, read pixel.
REQ-014 SHALL provide ports RAM_EN, RAM_WE (output, 1), RAM_ADDR (output, ADDR_W), RAM_WDATA (output, DATA_W): single-port synchronous VRAM control, all registered.
REQ-015 SHALL provide port RAM_RDATA, input, DATA_W, VRAM read data, valid one cycle after RAM_EN with RAM_WE=0.
REQ-016 SHALL provide port FIFO_LEVEL, output, log2(FIFO_DEPTH)+1, current write-buffer occupancy.
REQ-017 SHALL provide port OVERFLOW, output, 1, sticky dropped-write flag.
REQ-018 SHALL provide port CLR_OVF, input, 1, synchronous clear of OVERFLOW.

Function
REQ-019 SHALL discard, without FIFO entry or flag, any WR_REQ with WR_ADDR >= FRAME_PIXELS.
REQ-020 SHALL push in-range writes {addr,data} into the FIFO on the edge WR_REQ is sampled, if space exists after this cycle's pop.
REQ-021 SHALL give reads strict priority: cycle with RD_REQ=1 issues a read slot; otherwise, FIFO non-empty issues a write slot popping the head; otherwise idle.
REQ-022 SHALL register slot decision: on the edge after the decision, RAM_EN=1, RAM_WE=1 for write / 0 for read, RAM_ADDR/RAM_WDATA from the winner; idle slot drives RAM_EN=0, RAM_WE=0.
REQ-023 SHALL register RAM_RDATA into RD_DATA with RD_VALID=1 for exactly one cycle per read; fixed latency: RD_REQ sampled at edge N -> RD_VALID high during cycle after edge N+2.
REQ-024 SHALL preserve read order and never merge, drop or reorder reads; back-to-back reads yield back-to-back RD_VALID.
REQ-025 SHALL preserve write order; FIFO head always written before later entries.
REQ-026 SHALL, when FIFO is full, no pop occurs and an in-range WR_REQ arrives, drop that write and set OVERFLOW.
REQ-027 SHALL accept a push when full if a pop occurs the same cycle (level unchanged).
REQ-028 SHALL update FIFO_LEVEL each edge: +1 push only, -1 pop only, unchanged both/neither; never exceed FIFO_DEPTH nor underflow.
REQ-029 SHALL clear OVERFLOW on CLR_OVF=1; simultaneous new overflow and CLR_OVF leaves OVERFLOW=1.
REQ-030 SHALL leave RD_DATA holding last value when RD_VALID=0.

Reset
REQ-031 SHALL, on RST_N low, asynchronously force RAM_EN=0, RAM_WE=0, RAM_ADDR=0, RAM_WDATA=0, RD_VALID=0, RD_DATA=0, FIFO_LEVEL=0, OVERFLOW=0, FIFO pointers to 0.
REQ-032 SHALL discard buffered writes and in-flight reads on reset mid-operation; no RD_VALID for reads issued before reset.
REQ-033 SHALL sample requests from the first rising edge after RST_N deasserts.

Verification
REQ-034 SHALL cover: single WR_REQ addr 100 data 0xA5, no reads -> next edge level 1, following cycle RAM_EN=1 WE=1 ADDR=100 WDATA=0xA5, level 0.
REQ-035 SHALL cover: RD_REQ addr 5, RAM model returns 0x3C -> RD_VALID one cycle, exactly 3 edges later, RD_DATA=0x3C.
REQ-036 SHALL cover: 6 consecutive RD_REQ with 5 in-range WR_REQ concurrent -> 6 reads issued first, 4 writes buffered, 5th dropped, OVERFLOW=1, then 4 writes in order.
REQ-037 SHALL cover: WR_REQ addr 23040 and 23200 -> no FIFO entry, no RAM write, OVERFLOW stays 0.
REQ-038 SHALL cover: FIFO full, no RD_REQ, WR_REQ -> pop and push same cycle, level stays 4, OVERFLOW 0.
REQ-039 SHALL cover: RST_N low with 3 buffered writes and 2 reads in flight -> all outputs at reset values immediately, no further RAM_EN or RD_VALID.
